// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a registered-read FIFO and re-presents its data as a
// valid/ready stream through a two-entry buffer with read-credit accounting.
module fifo_stream_reader #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_rd_en,
    input  logic [WIDTH-1:0]       fifo_rd_data,
    input  logic                   fifo_rd_empty,
    output logic                   m_valid,
    output logic [WIDTH-1:0]       m_data,
    input  logic                   m_ready,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] words_out
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       occ;
    logic             inflight;

    logic [WIDTH-1:0] slot0_nxt;
    logic [WIDTH-1:0] slot1_nxt;
    logic [1:0]       occ_nxt;
    logic             pop;
    logic             arrive;
    logic [2:0]       credit;

    assign m_valid = (occ != 2'd0);
    assign m_data  = slot0;
    assign pop     = m_valid & m_ready;
    assign arrive  = inflight & ~flush;

    // Words buffered plus words in flight, after this cycle's pop frees a slot.
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = ~rst & ~flush & ~fifo_rd_empty & (credit < 3'd2);

    always_comb begin
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        occ_nxt   = occ;
        if (flush) begin
            occ_nxt = 2'd0;
        end else begin
            unique case (1'b1)
                pop & ~arrive: begin
                    slot0_nxt = slot1;
                    occ_nxt   = occ - 2'd1;
                end
                ~pop & arrive: begin
                    if (occ == 2'd0) begin
                        slot0_nxt = fifo_rd_data;
                    end else begin
                        slot1_nxt = fifo_rd_data;
                    end
                    occ_nxt = occ + 2'd1;
                end
                pop & arrive: begin
                    if (occ == 2'd2) begin
                        slot0_nxt = slot1;
                        slot1_nxt = fifo_rd_data;
                    end else begin
                        slot0_nxt = fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0     <= '0;
            slot1     <= '0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            slot0     <= slot0_nxt;
            slot1     <= slot1_nxt;
            occ       <= occ_nxt;
            inflight  <= fifo_rd_en;
            words_out <= words_out + {{(COUNT_WIDTH-1){1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a registered-read FIFO model.
// Directed phases run back to back; words_out expectations are cumulative.
module tb_fifo_stream_reader;

    localparam int W  = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic          flush;
    logic [CW-1:0] words_out;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .words_out    (words_out)
    );

    // FIFO model: data appears on fifo_rd_data the cycle after the pop.
    logic [W-1:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_rd_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    int ovf    = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] v, input bit delivered);
        mem[wr_ptr] = v;
        wr_ptr++;
        if (delivered) exp_q.push_back(v);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted word must be the oldest expected word.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_order act=%0h exp=none", m_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL mon_order act=%0h exp=%0h", m_data, e);
                end
            end
            n_acc++;
        end
    end

    // Arrival with no free slot, or an impossible occupancy.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.occ > 2'd2) ovf++;
            if (dut.inflight && !flush && dut.occ == 2'd2 &&
                !(m_valid && m_ready)) ovf++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int nrd;
        int bad;
        int cyc;
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push_word(W'(i), 1'b1);

        // Reset with a non-empty FIFO
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            next_cycle();
        end

        // Streaming 0x0001..0x0010
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_words_out", words_out, 32'd0);
        check("stream_first_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("stream_lat_c1", {31'd0, m_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("stream_lat_c2", {31'd0, m_valid}, 32'd1);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            @(negedge clk);
            if (m_valid) nv++;
        end
        check("stream_back_to_back", nv, 32'd15);
        next_cycle();
        @(negedge clk);
        check("stream_end_valid", {31'd0, m_valid}, 32'd0);
        check("stream_words_out", words_out, 32'd16);

        // Backpressure: 5 stall cycles after the second word is presented
        next_cycle();
        for (int i = 0; i < 8; i++) push_word(W'(16'h0021 + i), 1'b1);
        repeat (3) next_cycle();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
            check("bp_valid_held", {31'd0, m_valid}, 32'd1);
            check("bp_data_stable", {16'd0, m_data}, 32'h0022);
            next_cycle();
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        check("bp_resume_data", {16'd0, m_data}, 32'h0022);
        nv = 1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            if (m_valid) nv++;
        end
        check("bp_resume_no_gap", nv, 32'd7);
        next_cycle();
        @(negedge clk);
        check("bp_drained", {31'd0, m_valid}, 32'd0);
        check("bp_words_out", words_out, 32'd24);

        // Empty boundary: a single word
        next_cycle();
        push_word(16'h0031, 1'b1);
        nv  = 0;
        nrd = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en) nrd++;
            if (m_valid) nv++;
            if (fifo_rd_en && fifo_rd_empty) bad++;
            next_cycle();
        end
        check("empty_one_pop", nrd, 32'd1);
        check("empty_one_valid", nv, 32'd1);
        check("empty_no_pop_when_empty", bad, 32'd0);
        check("empty_words_out", words_out, 32'd25);

        // Flush mid-stream: 0x0103 popped in the flush cycle, 0x0104 in flight
        for (int i = 0; i < 8; i++)
            push_word(W'(16'h0101 + i), (i != 3));
        repeat (4) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("flush_pop_valid", {31'd0, m_valid}, 32'd1);
        check("flush_pop_data", {16'd0, m_data}, 32'h0103);
        check("flush_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid_low", {31'd0, m_valid}, 32'd0);
        check("flush_words_out", words_out, 32'd28);
        check("flush_fresh_pop", {31'd0, fifo_rd_en}, 32'd1);
        repeat (10) next_cycle();
        @(negedge clk);
        check("flush_drain_words_out", words_out, 32'd32);

        // Flush with both slots full and m_ready low
        next_cycle();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_word(W'(16'h0201 + i), (i >= 2));
        repeat (3) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("flush2_valid_before", {31'd0, m_valid}, 32'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush2_valid_low", {31'd0, m_valid}, 32'd0);
        check("flush2_words_out", words_out, 32'd32);
        next_cycle();
        m_ready = 1'b1;
        repeat (10) next_cycle();
        @(negedge clk);
        check("flush2_drain_words_out", words_out, 32'd35);

        // Random stall over 1000 words
        next_cycle();
        for (int i = 0; i < 1000; i++) push_word(W'(16'h1000 + i), 1'b1);
        cyc = 0;
        while (n_acc < 1035 && cyc < 6000) begin
            next_cycle();
            m_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            cyc++;
        end
        check("rand_completed", {31'd0, 1'(n_acc >= 1035)}, 32'd1);
        next_cycle();
        m_ready = 1'b0;
        @(negedge clk);
        check("rand_words_out", words_out, 32'd1035);
        check("rand_scoreboard_empty", exp_q.size(), 32'd0);
        check("rand_fifo_empty", {31'd0, fifo_rd_empty}, 32'd1);
        check("no_overflow", ovf, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the GPU's registered-read synchronous FIFOs. It issues pops into a FIFO whose read data arrives one cycle after the read enable, and re-presents that data as a registered valid/ready stream toward downstream consumers such as the command decoder or pixel pipeline. A two-entry output buffer with read-credit accounting sustains one word per cycle under backpressure. The block also supports a flush of buffered and in-flight data, and keeps a running count of words delivered.

## Interface
- WIDTH, 16: data word width; must match the attached FIFO.
- COUNT_WIDTH, 32: width of the delivered-word counter.
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_rd_en  output  1  pop request to the FIFO (FIFO read enable).
- fifo_rd_data  input  WIDTH  FIFO read data; valid the cycle after an accepted pop.
- fifo_rd_empty  input  1  FIFO empty flag.
- m_valid  output  1  output word available.
- m_data  output  WIDTH  output word; registered.
- m_ready  input  1  downstream accepts the word this cycle.
- flush  input  1  discard all buffered and in-flight words.
- words_out  output  COUNT_WIDTH  total words accepted downstream; wraps modulo 2^COUNT_WIDTH.

## Operation
- **State:**
  - slot0 is the head, driven onto m_data.
  - slot1 is the skid entry.
  - occ is the number of buffered words, 0..2.
  - inflight is a registered bit: 1 when fifo_rd_en was high last cycle.
- **Pop:** pop = m_valid & m_ready. m_valid = (occ != 0).
- **Credit rule:** fifo_rd_en = !rst & !flush & !fifo_rd_empty & ((occ + inflight - pop) < 2).
  - This is a combinational path from m_ready and fifo_rd_empty to fifo_rd_en; it is intentional and required for full throughput.
- **Arrival:** when inflight=1 and flush=0, fifo_rd_data is written into the first free slot after accounting for this cycle's pop.
  - Pop with no arrival: slot1 shifts to slot0.
  - Pop with arrival at occ=1: the arriving word loads slot0.
  - Pop with arrival at occ=2: slot1 shifts to slot0 and the arriving word loads slot1.
- **Ordering:** words leave in strict FIFO order; there is no drop or duplication except by flush.
- **Overflow:** the credit rule guarantees occ never exceeds 2. An arrival with no free slot is a design error; the bench asserts that it never occurs.
- **Flush:** in the flush cycle, occ is cleared to 0 and any arriving in-flight word is discarded.
  - fifo_rd_en is held 0, so nothing is in flight after flush.
  - A pop in the flush cycle is still honoured; words_out counts it.
  - Words remaining inside the FIFO are not drained.
- **Counter:** words_out increments by 1 on each pop and is cleared only by rst.
- **Reset:** while rst is high:
  - fifo_rd_en = 0.
  - On the next edge: occ = 0, inflight = 0, slot0 = slot1 = 0, words_out = 0.
  - After reset: m_valid = 0 and m_data = 0.
- **Simultaneous rst and flush:** rst wins.

## Timing
- **Latency:** fifo_rd_en high in cycle N; the data word is on fifo_rd_data in N+1, captured at the end of N+1; m_valid is high in N+2.
- **Minimum latency** from fifo_rd_empty deasserting to m_valid: 2 cycles.
- **Throughput:** 1 word/cycle steady state with m_ready held high and the FIFO non-empty.
- **Backpressure:** when m_ready drops, at most one further word arrives, which fills slot1. No pops are issued while occ + inflight = 2.
- **Ready/valid rules:**
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid never deasserts without a pop, flush or rst.
- **Resume:** m_ready rising with occ=2 yields back-to-back valid words from slot0 then slot1, with a new pop issued in the same cycle.
- **Flush recovery:** m_valid = 0 the cycle after flush. The first fresh pop may be issued the cycle after flush deasserts.

## Test plan
- **Reset:** hold rst 3 cycles with the FIFO non-empty -> fifo_rd_en=0 throughout; afterwards m_valid=0, m_data=0, words_out=0.
- **Streaming:** FIFO preloaded with 0x0001..0x0010, m_ready=1 -> first m_valid 2 cycles after the first fifo_rd_en; 16 consecutive words 0x0001..0x0010 on consecutive cycles; words_out=16.
- **Backpressure:** streaming, then m_ready=0 for 5 cycles -> occ reaches 2, fifo_rd_en=0, m_data held stable; on release, 0x0003, 0x0004 follow back-to-back with no gaps or loss.
- **Empty boundary:** FIFO holds 1 word, m_ready=1 -> exactly one pop; fifo_rd_en stays 0 while fifo_rd_empty=1; m_valid for exactly 1 cycle.
- **Flush:** flush with occ=2 and inflight=1 -> next cycle m_valid=0; the in-flight word is never output; the next output is the FIFO's next word after the discarded in-flight word (e.g. 0x0007 after 0x0004/0x0005 buffered and 0x0006 in flight); words_out is unchanged by discarded words.
- **Random stall:** random m_ready (50%) over 1000 words -> output order is the same as the write order, the occ≤2 assertion holds, and words_out=1000.
